// File: rtl/alu_operand_regfile.sv
// Architectural register file for alu_gate: serves rs1/rs2 operand reads through a
// single-entry registered response stage and accepts results on a never-stalling write-back channel.
module alu_operand_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_req_valid_i,
    output logic                  rd_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
    output logic                  rd_rsp_valid_o,
    input  logic                  rd_rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rs1_data_o,
    output logic [DATA_WIDTH-1:0] rs2_data_o,
    input  logic                  wb_valid_i,
    output logic                  wb_ready_o,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rs1_q;
    logic [DATA_WIDTH-1:0] rs2_q;

    logic                  req_fire;
    logic                  wb_fire;
    logic                  wb_en;
    logic [DATA_WIDTH-1:0] rs1_next;
    logic [DATA_WIDTH-1:0] rs2_next;

    // Handshake: a transfer happens on any rising edge where valid and ready are both 1.
    // Valid never depends on ready; the only combinational path is rd_rsp_ready_i -> rd_req_ready_o.
    assign rd_req_ready_o = !rst_i && (!rsp_valid_q || rd_rsp_ready_i);
    assign wb_ready_o     = !rst_i;
    assign req_fire       = rd_req_valid_i && rd_req_ready_o;
    assign wb_fire        = wb_valid_i && wb_ready_o;
    assign wb_en          = wb_fire && !((ZERO_REG != 0) && (rd_addr_i == '0));

    // wb_en already excludes register 0, so the bypass is suppressed there too.
    always_comb begin
        rs1_next = regs[rs1_addr_i];
        rs2_next = regs[rs2_addr_i];
        if (wb_en && (rd_addr_i == rs1_addr_i)) begin
            rs1_next = rd_data_i;
        end
        if (wb_en && (rd_addr_i == rs2_addr_i)) begin
            rs2_next = rd_data_i;
        end
        if ((ZERO_REG != 0) && (rs1_addr_i == '0)) begin
            rs1_next = '0;
        end
        if ((ZERO_REG != 0) && (rs2_addr_i == '0)) begin
            rs2_next = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[rd_addr_i] <= rd_data_i;
        end
    end

    // Response registers only load on acceptance, which gives snapshot semantics under stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
        end else begin
            if (req_fire) begin
                rsp_valid_q <= 1'b1;
                rs1_q       <= rs1_next;
                rs2_q       <= rs2_next;
            end else if (rd_rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rd_rsp_valid_o = rsp_valid_q;
    assign rs1_data_o     = rs1_q;
    assign rs2_data_o     = rs2_q;

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Self-checking bench for alu_operand_regfile: directed scenarios plus a randomized
// stream checked against a register model and an expected-response queue.
module tb_alu_operand_regfile;

  logic        clk;
  logic        rst_i;
  logic        rd_req_valid_i;
  logic        rd_req_ready_o;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic        rd_rsp_valid_o;
  logic        rd_rsp_ready_i;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic        wb_valid_i;
  logic        wb_ready_o;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;

  logic [31:0] model [32];
  logic [63:0] exp_q [$];
  int n_checks;
  int n_errors;

  alu_operand_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rd_rsp_valid_o(rd_rsp_valid_o), .rd_rsp_ready_i(rd_rsp_ready_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
    .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks (inputs change just after the falling edge)
  task automatic set_req(input logic v, input logic [4:0] a1, input logic [4:0] a2);
    rd_req_valid_i = v;
    rs1_addr_i = a1;
    rs2_addr_i = a2;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb_valid_i = v;
    rd_addr_i = a;
    rd_data_i = d;
  endtask

  // Advance one cycle; maintain the register model and the expected-response queue.
  task automatic tick();
    logic req_fire, wb_fire, rsp_fire, in_rst;
    logic [31:0] e1, e2;
    logic [63:0] dropped;
    #1;
    in_rst   = rst_i;
    req_fire = rd_req_valid_i && rd_req_ready_o;
    wb_fire  = wb_valid_i && wb_ready_o;
    rsp_fire = rd_rsp_valid_o && rd_rsp_ready_i;
    e1 = (rs1_addr_i == 5'd0) ? 32'd0 :
         (wb_fire && rd_addr_i == rs1_addr_i) ? rd_data_i : model[rs1_addr_i];
    e2 = (rs2_addr_i == 5'd0) ? 32'd0 :
         (wb_fire && rd_addr_i == rs2_addr_i) ? rd_data_i : model[rs2_addr_i];
    if (rsp_fire && exp_q.size() > 0) dropped = exp_q.pop_front();
    if (req_fire) exp_q.push_back({e1, e2});
    if (wb_fire && rd_addr_i != 5'd0) model[rd_addr_i] = rd_data_i;
    @(posedge clk);
    @(negedge clk);
    if (in_rst) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    n_checks++;
    if (rd_rsp_valid_o !== 1'b0 || rs1_data_o !== 32'd0 || rs2_data_o !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: valid=%b rs1=%h rs2=%h, expected 0 0 0", rd_rsp_valid_o, rs1_data_o, rs2_data_o);
    end
    n_checks++;
    if (wb_ready_o !== 1'b0 || rd_req_ready_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ready: wb_ready=%b req_ready=%b, expected 0 0", wb_ready_o, rd_req_ready_o);
    end
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (wb_ready_o !== 1'b1 || rd_req_ready_o !== 1'b1) begin
      n_errors++;
      $display("FAIL post_reset_ready: wb_ready=%b req_ready=%b, expected 1 1", wb_ready_o, rd_req_ready_o);
    end
    set_req(1'b1, 5'd3, 5'd7);
    tick();
    set_req(1'b0, 5'd0, 5'd0);
    n_checks++;
    if (rd_rsp_valid_o !== 1'b1 || rs1_data_o !== 32'd0 || rs2_data_o !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_read: valid=%b rs1=%h rs2=%h, expected 1 0 0", rd_rsp_valid_o, rs1_data_o, rs2_data_o);
    end
    tick();
    n_checks++;
    if (rd_rsp_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL rsp_clear: valid=%b, expected 0", rd_rsp_valid_o);
    end
  endtask

  task automatic test_write_read();
    set_wb(1'b1, 5'd4, 32'hDEADBEEF);
    tick();
    set_wb(1'b1, 5'd9, 32'h0000FFFF);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    set_req(1'b1, 5'd4, 5'd9);
    #1;
    n_checks++;
    if (rd_rsp_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL wr_rd_early_valid: valid=%b, expected 0", rd_rsp_valid_o);
    end
    tick();
    set_req(1'b0, 5'd0, 5'd0);
    n_checks++;
    if (rd_rsp_valid_o !== 1'b1 || rs1_data_o !== 32'hDEADBEEF || rs2_data_o !== 32'h0000FFFF) begin
      n_errors++;
      $display("FAIL write_read: valid=%b rs1=%h rs2=%h, expected 1 deadbeef 0000ffff", rd_rsp_valid_o, rs1_data_o, rs2_data_o);
    end
    tick();
  endtask

  task automatic test_bypass();
    set_wb(1'b1, 5'd5, 32'h11111111);
    tick();
    set_wb(1'b1, 5'd5, 32'hA5A5A5A5);
    set_req(1'b1, 5'd5, 5'd5);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    set_req(1'b0, 5'd0, 5'd0);
    n_checks++;
    if (rd_rsp_valid_o !== 1'b1 || rs1_data_o !== 32'hA5A5A5A5 || rs2_data_o !== 32'hA5A5A5A5) begin
      n_errors++;
      $display("FAIL bypass: valid=%b rs1=%h rs2=%h, expected 1 a5a5a5a5 a5a5a5a5", rd_rsp_valid_o, rs1_data_o, rs2_data_o);
    end
    tick();
  endtask

  task automatic test_backpressure();
    set_wb(1'b1, 5'd2, 32'h12345678);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    rd_rsp_ready_i = 1'b0;
    set_req(1'b1, 5'd2, 5'd2);
    tick();
    set_req(1'b0, 5'd0, 5'd0);
    for (int c = 0; c < 4; c++) begin
      if (c == 0) set_wb(1'b1, 5'd2, 32'hCAFEF00D);
      else set_wb(1'b0, 5'd0, 32'd0);
      #1;
      n_checks++;
      if (rd_rsp_valid_o !== 1'b1 || rs1_data_o !== 32'h12345678 || rs2_data_o !== 32'h12345678 || rd_req_ready_o !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: valid=%b rs1=%h rs2=%h req_ready=%b, expected 1 12345678 12345678 0",
                 c, rd_rsp_valid_o, rs1_data_o, rs2_data_o, rd_req_ready_o);
      end
      tick();
    end
    rd_rsp_ready_i = 1'b1;
    set_req(1'b1, 5'd2, 5'd2);
    tick();
    set_req(1'b0, 5'd0, 5'd0);
    n_checks++;
    if (rd_rsp_valid_o !== 1'b1 || rs1_data_o !== 32'hCAFEF00D || rs2_data_o !== 32'hCAFEF00D) begin
      n_errors++;
      $display("FAIL reread: valid=%b rs1=%h rs2=%h, expected 1 cafef00d cafef00d", rd_rsp_valid_o, rs1_data_o, rs2_data_o);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    set_wb(1'b1, 5'd0, 32'hFFFFFFFF);
    set_req(1'b1, 5'd0, 5'd0);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    n_checks++;
    if (rd_rsp_valid_o !== 1'b1 || rs1_data_o !== 32'd0 || rs2_data_o !== 32'd0) begin
      n_errors++;
      $display("FAIL zero_bypass: valid=%b rs1=%h rs2=%h, expected 1 0 0", rd_rsp_valid_o, rs1_data_o, rs2_data_o);
    end
    tick();
    set_req(1'b0, 5'd0, 5'd0);
    n_checks++;
    if (rd_rsp_valid_o !== 1'b1 || rs1_data_o !== 32'd0 || rs2_data_o !== 32'd0) begin
      n_errors++;
      $display("FAIL zero_read: valid=%b rs1=%h rs2=%h, expected 1 0 0", rd_rsp_valid_o, rs1_data_o, rs2_data_o);
    end
    tick();
  endtask

  // Random traffic; phase 1 randomizes rd_rsp_ready_i, phase 2 holds it high to check throughput.
  task automatic test_random();
    int stall_errs;
    int data_errs;
    int tput_errs;
    stall_errs = 0;
    data_errs  = 0;
    tput_errs  = 0;
    for (int t = 0; t < 1000; t++) begin
      rd_rsp_ready_i = (t < 600) ? ($urandom_range(0, 3) != 0) : 1'b1;
      set_req((t < 600) ? ($urandom_range(0, 4) != 0) : 1'b1,
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      set_wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
      if (t >= 600) begin
        #1;
        n_checks++;
        if (rd_req_ready_o !== 1'b1) begin
          tput_errs++;
          n_errors++;
          $display("FAIL throughput[%0d]: req_ready=%b, expected 1", t, rd_req_ready_o);
        end
      end
      tick();
      n_checks++;
      if (rd_rsp_valid_o !== (exp_q.size() != 0)) begin
        stall_errs++;
        n_errors++;
        $display("FAIL rand_valid[%0d]: valid=%b, expected %b", t, rd_rsp_valid_o, exp_q.size() != 0);
      end else if (rd_rsp_valid_o) begin
        n_checks++;
        if ({rs1_data_o, rs2_data_o} !== exp_q[0]) begin
          data_errs++;
          n_errors++;
          $display("FAIL rand_data[%0d]: rs1=%h rs2=%h, expected %h %h", t, rs1_data_o, rs2_data_o, exp_q[0][63:32], exp_q[0][31:0]);
        end
      end
    end
    // Mid-stream reset with a pending response
    rd_rsp_ready_i = 1'b0;
    set_wb(1'b1, 5'd6, 32'h600D600D);
    set_req(1'b1, 5'd6, 5'd1);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    set_req(1'b0, 5'd0, 5'd0);
    rst_i = 1'b1;
    tick();
    n_checks++;
    if (rd_rsp_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_valid: valid=%b, expected 0", rd_rsp_valid_o);
    end
    rst_i = 1'b0;
    rd_rsp_ready_i = 1'b1;
    for (int r = 0; r < 32; r += 2) begin
      set_req(1'b1, 5'(r), 5'(r + 1));
      tick();
      n_checks++;
      if (rd_rsp_valid_o !== 1'b1 || {rs1_data_o, rs2_data_o} !== 64'd0) begin
        n_errors++;
        $display("FAIL midreset_regs[%0d]: valid=%b rs1=%h rs2=%h, expected 1 0 0", r, rd_rsp_valid_o, rs1_data_o, rs2_data_o);
      end
    end
    set_req(1'b0, 5'd0, 5'd0);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    rst_i = 1'b1;
    rd_rsp_ready_i = 1'b1;
    set_req(1'b0, 5'd0, 5'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_backpressure();
    test_zero_reg();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
